// File: rtl/reg_write_ctrl_pkg.sv
// Shared register-file definitions for the writeback controller.
// Provides the register count, index width, zero-register index, occupancy
// counter width and the controller state encoding.
package reg_write_ctrl_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned PEND_W    = 4;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = REG_IDX_W'(0);

  // IDLE: buffer empty; DRAIN: entries and last hold low; STALL: entries and hold high
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } wstate_t;

endpackage

// File: rtl/decoder5to32.sv
// One-hot register write-strobe decoder.
// Ports: idx   - register index to strobe
//        en    - strobe enable; all outputs low when clear
//        sel_c - combinational one-hot strobe vector (bit n = register n)
module decoder5to32
  import reg_write_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  sel_c
);

  always_comb begin
    sel_c = '0;
    if (en) sel_c = NUM_REGS'(1) << idx;
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Register-file writeback controller: buffers writebacks in a small FIFO and
// commits them one per cycle onto the shared D bus with a one-hot Dselect.
// Ports: clk/reset        - clock, synchronous active-high reset
//        wr_valid/wr_ready - writeback handshake; wr_rd/wr_data the payload
//        hold             - register file cannot take a write this cycle
//        D/Dselect        - registered data bus and one-hot write strobes
//        rs_a/rs_b        - read indices checked against buffered writes
//        hazard           - a read index matches a not-yet-committed write
//        pending          - buffer occupancy
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [REG_IDX_W-1:0] wr_rd,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 hold,
  output logic [WIDTH-1:0]     D,
  output logic [NUM_REGS-1:0]  Dselect,
  input  logic [REG_IDX_W-1:0] rs_a,
  input  logic [REG_IDX_W-1:0] rs_b,
  output logic                 hazard,
  output logic [PEND_W-1:0]    pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [REG_IDX_W-1:0] rd_q   [DEPTH];
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  wstate_t              state_q, state_d;
  logic [PEND_W-1:0]    pending_d;
  logic                 commit_c, accept_c, push_c;
  logic [NUM_REGS-1:0]  dsel_c;

  // Commit decision, handshake and occupancy/state update
  always_comb begin
    commit_c  = 1'b0;
    wr_ready  = 1'b0;
    accept_c  = 1'b0;
    push_c    = 1'b0;
    pending_d = pending;
    state_d   = state_q;

    case (state_q)
      IDLE:         commit_c = 1'b0;
      DRAIN, STALL: commit_c = !hold;
      default:      commit_c = 1'b0;
    endcase

    // a full buffer still accepts when its head leaves this cycle
    wr_ready = !reset && ((pending < PEND_W'(DEPTH)) || commit_c);
    accept_c = wr_valid && wr_ready;
    // writes to the zero register complete the handshake but are not stored
    push_c   = accept_c && (wr_rd != REG_ZERO);

    if (push_c && !commit_c)      pending_d = pending + PEND_W'(1);
    else if (!push_c && commit_c) pending_d = pending - PEND_W'(1);

    if (pending_d == '0) state_d = IDLE;
    else if (hold)       state_d = STALL;
    else                 state_d = DRAIN;
  end

  // Hazard: any occupied slot whose destination matches a nonzero read index
  always_comb begin
    logic [PTR_W-1:0] offs;
    hazard = 1'b0;
    offs   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rptr_q;
      if (PEND_W'(offs) < pending) begin
        if ((rs_a != REG_ZERO && rd_q[i] == rs_a) ||
            (rs_b != REG_ZERO && rd_q[i] == rs_b))
          hazard = 1'b1;
      end
    end
    if (reset) hazard = 1'b0;
  end

  decoder5to32 u_dec (
    .idx   (rd_q[rptr_q]),
    .en    (commit_c),
    .sel_c (dsel_c)
  );

  // Control state, pointers and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pending <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      Dselect <= '0;
      D       <= '0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      Dselect <= dsel_c;
      if (push_c) wptr_q <= wptr_q + PTR_W'(1);
      if (commit_c) begin
        rptr_q <= rptr_q + PTR_W'(1);
        D      <= data_q[rptr_q];
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) begin
      rd_q[wptr_q]   <= wr_rd;
      data_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed vector table, a streaming
// sequence, then randomized traffic against a queue-based reference model.
module tb_reg_write_ctrl;

  localparam int unsigned TB_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_rd = '0;
  logic [31:0] wr_data = '0;
  logic        hold = 1'b0;
  logic [31:0] D;
  logic [31:0] Dselect;
  logic [4:0]  rs_a = '0;
  logic [4:0]  rs_b = '0;
  logic        hazard;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  reg_write_ctrl #(.DEPTH(TB_DEPTH), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rd(wr_rd), .wr_data(wr_data), .hold(hold), .D(D), .Dselect(Dselect),
    .rs_a(rs_a), .rs_b(rs_b), .hazard(hazard), .pending(pending)
  );

  int errors = 0;
  int nchecks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain FIFO queue of pending writes
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_dsel = '0;
  logic [31:0] m_d = '0;

  function automatic logic model_ready();
    if (reset) return 1'b0;
    return (mq.size() < TB_DEPTH) || (mq.size() > 0 && !hold);
  endfunction

  function automatic logic model_hazard();
    if (reset) return 1'b0;
    foreach (mq[k])
      if ((rs_a != 0 && mq[k].rd == rs_a) || (rs_b != 0 && mq[k].rd == rs_b)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check combinational outputs, advance the model at the edge,
  // then check the registered outputs away from the edge.
  task automatic cycle();
    logic rdy;
    ent_t e;
    rdy = model_ready();
    check("model_wr_ready", wr_ready, rdy);
    check("model_hazard", hazard, model_hazard());
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_dsel = '0;
      m_d    = '0;
    end else begin
      if (mq.size() > 0 && !hold) begin
        m_dsel = 32'd1 << mq[0].rd;
        m_d    = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_dsel = '0;
      end
      if (wr_valid && rdy && wr_rd != 0) begin
        e.rd = wr_rd;
        e.data = wr_data;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    check("model_pending", pending, 64'(mq.size()));
    check("model_Dselect", Dselect, m_dsel);
    check("model_D", D, m_d);
  endtask

  // Directed vectors: inputs, pre-edge ready/hazard, post-edge pending/Dselect/D
  typedef struct {
    logic r; logic v; logic [4:0] rd; logic [31:0] dat; logic h;
    logic [4:0] a; logic [4:0] b;
    logic er; logic eh; logic [3:0] ep; logic [31:0] eds; logic [31:0] ed;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] dat,
                     input logic h, input logic [4:0] a, input logic [4:0] b,
                     input logic er, input logic eh, input logic [3:0] ep,
                     input logic [31:0] eds, input logic [31:0] ed);
    vec_t x;
    x.r = r; x.v = v; x.rd = rd; x.dat = dat; x.h = h; x.a = a; x.b = b;
    x.er = er; x.eh = eh; x.ep = ep; x.eds = eds; x.ed = ed;
    vq.push_back(x);
  endtask

  initial begin
    // reset state
    add(1,1,4,32'h1,0,0,0,            0,0,0,32'h0,32'h0);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h0);
    // single write rd=5
    add(0,1,5,32'hDEADBEEF,0,0,0,     1,0,1,32'h0,32'h0);
    add(0,0,0,0,0,0,0,                1,0,0,32'h20,32'hDEADBEEF);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'hDEADBEEF);
    // write to r0 is dropped
    add(0,1,0,32'h12345678,0,0,0,     1,0,0,32'h0,32'hDEADBEEF);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'hDEADBEEF);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'hDEADBEEF);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'hDEADBEEF);
    // fill under hold, refuse a third, then drain in order
    add(0,1,3,32'h33,1,0,0,           1,0,1,32'h0,32'hDEADBEEF);
    add(0,1,7,32'h77,1,0,0,           1,0,2,32'h0,32'hDEADBEEF);
    add(0,1,9,32'h99,1,3,7,           0,1,2,32'h0,32'hDEADBEEF);
    add(0,0,0,0,0,0,0,                1,0,1,32'h8,32'h33);
    add(0,0,0,0,0,0,0,                1,0,0,32'h80,32'h77);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h77);
    // hazard on buffered rd=9
    add(0,1,9,32'h99,1,9,0,           1,0,1,32'h0,32'h77);
    add(0,0,0,0,1,9,0,                1,1,1,32'h0,32'h77);
    add(0,0,0,0,1,0,9,                1,1,1,32'h0,32'h77);
    add(0,0,0,0,1,0,0,                1,0,1,32'h0,32'h77);
    add(0,0,0,0,0,9,0,                1,1,0,32'h200,32'h99);
    add(0,0,0,0,0,9,0,                1,0,0,32'h0,32'h99);
    // reset with two entries buffered
    add(0,1,10,32'hA,1,0,0,           1,0,1,32'h0,32'h99);
    add(0,1,11,32'hB,1,0,0,           1,0,2,32'h0,32'h99);
    add(1,0,0,0,0,0,0,                0,0,0,32'h0,32'h0);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h0);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h0);
    // full buffer accepts while committing
    add(0,1,1,32'h1,1,0,0,            1,0,1,32'h0,32'h0);
    add(0,1,2,32'h2,1,0,0,            1,0,2,32'h0,32'h0);
    add(0,1,4,32'h4,0,0,0,            1,0,2,32'h2,32'h1);
    add(0,0,0,0,0,0,0,                1,0,1,32'h4,32'h2);
    add(0,0,0,0,0,0,0,                1,0,0,32'h10,32'h4);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h4);
    // same destination twice: both commit, last wins
    add(0,1,6,32'h61,1,0,0,           1,0,1,32'h0,32'h4);
    add(0,1,6,32'h62,1,0,0,           1,0,2,32'h0,32'h4);
    add(0,0,0,0,0,0,0,                1,0,1,32'h40,32'h61);
    add(0,0,0,0,0,0,0,                1,0,0,32'h40,32'h62);
    add(0,0,0,0,0,0,0,                1,0,0,32'h0,32'h62);

    @(negedge clk);
    foreach (vq[i]) begin
      reset = vq[i].r; wr_valid = vq[i].v; wr_rd = vq[i].rd; wr_data = vq[i].dat;
      hold = vq[i].h; rs_a = vq[i].a; rs_b = vq[i].b;
      #1;
      check($sformatf("vec%0d_wr_ready", i), wr_ready, vq[i].er);
      check($sformatf("vec%0d_hazard", i), hazard, vq[i].eh);
      cycle();
      check($sformatf("vec%0d_pending", i), pending, vq[i].ep);
      check($sformatf("vec%0d_Dselect", i), Dselect, vq[i].eds);
      check($sformatf("vec%0d_D", i), D, vq[i].ed);
    end

    // back-to-back streaming of eight writes
    for (int j = 0; j < 10; j++) begin
      reset = 1'b0; hold = 1'b0; rs_a = '0; rs_b = '0;
      wr_valid = (j < 8);
      wr_rd = 5'(j + 1);
      wr_data = 32'hA0 + 32'(j);
      #1;
      cycle();
      check($sformatf("stream%0d_pend_le1", j), 64'(pending <= 4'd1), 64'd1);
      if (j == 0 || j == 9) check($sformatf("stream%0d_Dselect", j), Dselect, 32'h0);
      else check($sformatf("stream%0d_Dselect", j), Dselect, 32'd1 << j);
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_rd    = 5'($urandom_range(0, 15));
      wr_data  = $urandom;
      hold     = ($urandom_range(0, 2) == 0);
      rs_a     = 5'($urandom_range(0, 15));
      rs_b     = 5'($urandom_range(0, 15));
      #1;
      cycle();
      check("rand_no_r0_strobe", 64'(Dselect[0]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 SHALL use parameter DEPTH, default 2, as the number of pending-write buffer entries (power of two, 2..8).
REQ-002 SHALL use parameter WIDTH, default 32, as the data width of the D bus.
REQ-003 SHALL have port clk, input, 1, the single clock for the block; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, the producer offers a writeback.
REQ-006 SHALL have port wr_ready, output, 1, the block accepts the offered writeback this cycle.
REQ-007 SHALL have port wr_rd, input, 5, the destination register index.
REQ-008 SHALL have port wr_data, input, WIDTH, the writeback value.
REQ-009 SHALL have port hold, input, 1, the register file cannot take a write this cycle.
REQ-010 SHALL have port D, output, WIDTH, the data bus to all registers.
REQ-011 SHALL have port Dselect, output, 32, one-hot register write strobes (bit n = register n).
REQ-012 SHALL have port rs_a, input, 5, the index being read onto abus.
REQ-013 SHALL have port rs_b, input, 5, the index being read onto bbus.
REQ-014 SHALL have port hazard, output, 1, rs_a or rs_b matches a buffered, not-yet-committed write.
REQ-015 SHALL have port pending, output, 4, the buffer occupancy count.

Function
REQ-016 SHALL accept an entry when wr_valid && wr_ready on a rising edge of clk.
REQ-017 SHALL drive wr_ready = (pending < DEPTH) || commit-this-cycle, so a full buffer accepts and commits in the same cycle.
REQ-018 SHALL drop writes with wr_rd == 0 at acceptance: handshake completes, no entry is stored, pending does not change, and Dselect[0] is never asserted.
REQ-019 SHALL drive D and Dselect from the head entry as registered outputs, so data is visible one cycle after acceptance at the earliest.
REQ-020 SHALL commit the head entry in any cycle with pending > 0 && !hold, asserting exactly one Dselect bit for that cycle.
REQ-021 SHALL drive Dselect to all zeros whenever pending == 0 or hold == 1; D then holds its last value.
REQ-022 SHALL commit entries in acceptance order (FIFO), with read/write pointers wrapping modulo DEPTH.
REQ-023 SHALL update pending as +1 on accept-only, -1 on commit-only, and unchanged on simultaneous accept and commit.
REQ-024 SHALL compute hazard combinationally as the OR over valid entries of (rd == rs_a && rs_a != 0) || (rd == rs_b && rs_b != 0); it is 0 when the buffer is empty.
REQ-025 SHALL, for two buffered writes to the same rd, commit both in order; the last one wins.
REQ-026 SHALL use three states: IDLE (pending == 0), DRAIN (pending > 0, !hold), and STALL (pending > 0, hold); transitions follow pending and hold each cycle.

Reset
REQ-027 SHALL, while reset is high at a rising edge, clear pending, both pointers, Dselect, D, and the state (to IDLE); wr_ready is 0 and hazard is 0 during reset.
REQ-028 SHALL discard buffered entries on reset mid-drain, with no Dselect pulse in the cycle following reset.

Structure
REQ-029 SHALL place the register count (32), index width (5), and the zero-register index constant in the shared register-file defines file.
REQ-030 SHALL instantiate one sub-module, decoder5to32, for the one-hot Dselect decode.

Verification
REQ-031 SHALL verify single write: accept rd=5, data=0xDEADBEEF with hold=0 -> the next cycle Dselect=0x00000020 and D=0xDEADBEEF for one cycle, then Dselect=0.
REQ-032 SHALL verify r0 drop: accept rd=0, data=0x12345678 -> pending stays 0 and Dselect remains 0 for 4 cycles.
REQ-033 SHALL verify full with hold: hold=1, accept rd=3 and rd=7 -> pending=2 and wr_ready=0; release hold -> Dselect=0x8 then 0x80 on consecutive cycles.
REQ-034 SHALL verify hazard: buffer holds rd=9 with hold=1, rs_a=9 -> hazard=1; rs_a=0, rs_b=0 -> hazard=0; after commit -> hazard=0.
REQ-035 SHALL verify reset mid-drain: two entries buffered, assert reset for 1 cycle -> pending=0, Dselect=0 thereafter, and wr_ready=1 the next cycle.
REQ-036 SHALL verify back-to-back streaming: 8 writes with wr_valid=1 every cycle and hold=0 -> 8 consecutive single-bit Dselect pulses in order and pending never above 1.
